// File: rtl/down_count_timer_if.sv
// Control/status bundle of the loadable down-count timer.
// Signal suffixes are relative to the timer: _i driven by the master, _o by the timer.
interface down_count_timer_if #(
   parameter int WIDTH = 4
);
   logic             load_i;
   logic [WIDTH-1:0] din_i;
   logic             start_i;
   logic             stop_i;
   logic             en_i;
   logic [WIDTH-1:0] q_o;
   logic             busy_o;
   logic             done_o;
   logic             tc_o;

   modport master (
      output load_i, din_i, start_i, stop_i, en_i,
      input  q_o, busy_o, done_o, tc_o
   );

   modport slave (
      input  load_i, din_i, start_i, stop_i, en_i,
      output q_o, busy_o, done_o, tc_o
   );
endinterface

// File: rtl/down_count_timer.sv
// Loadable down counter with IDLE/RUN/DONE control and a one-cycle terminal-count pulse.
// Optional DOWN_COUNT_TIMER_AUTO_RELOAD_EN: reload and keep running at terminal count.
//
// state  | meaning
// S_IDLE | loaded or stopped, waiting for start
// S_RUN  | counting down on each en tick
// S_DONE | reached zero; start reloads and restarts
module down_count_timer #(
   parameter int WIDTH = 4
) (
   input logic               clk,
   input logic               rst,
   down_count_timer_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             tc_q, tc_d;
   logic             busy_q, done_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      tc_d     = 1'b0;
      if (bus.load_i) begin
         cnt_d    = bus.din_i;
         reload_d = bus.din_i;
         state_d  = S_IDLE;
      end else if (bus.stop_i && (state_q == S_RUN)) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start_i) begin
                  if (cnt_q != '0) begin
                     state_d = S_RUN;
                  end else begin
                     tc_d    = 1'b1;
                     state_d = S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (bus.start_i) begin
                  cnt_d = reload_q;
                  if (reload_q != '0) state_d = S_RUN;
                  else                tc_d    = 1'b1;
               end
            end
            S_RUN: begin
               // cnt_q is never zero in RUN; the guard only keeps the count from wrapping
               if (bus.en_i && (cnt_q != '0)) begin
                  if (cnt_q == WIDTH'(1)) begin
                     tc_d = 1'b1;
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                     if (reload_q != '0) begin
                        cnt_d = reload_q;
                     end else begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                     end
`else
                     cnt_d   = '0;
                     state_d = S_DONE;
`endif
                  end else begin
                     cnt_d = cnt_q - WIDTH'(1);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
         busy_q   <= (state_d == S_RUN);
         done_q   <= (state_d == S_DONE);
      end
   end

   assign bus.q_o    = cnt_q;
   assign bus.busy_o = busy_q;
   assign bus.done_o = done_q;
   assign bus.tc_o   = tc_q;
endmodule

// File: tb/tb_down_count_timer.sv
// Self-checking bench for down_count_timer: vector table with a scoreboard queue,
// plus hand sequences for async reset mid-count and a bounded wait for terminal count.
module tb_down_count_timer;
   typedef struct {
      string      name;
      logic       load;
      logic [3:0] din;
      logic       start;
      logic       stop;
      logic       en;
      logic [3:0] q;
      logic       busy;
      logic       done;
      logic       tc;
   } vec_t;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   vec_t tbl[$];
   vec_t sb_q[$];

   down_count_timer_if #(.WIDTH(4)) bus ();

   down_count_timer #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   task automatic add(input string n, input bit ld, input int d, input bit st, input bit sp,
                      input bit e, input int eq, input bit eb, input bit ed, input bit et);
      vec_t v;
      v.name = n; v.load = ld; v.din = 4'(d); v.start = st; v.stop = sp; v.en = e;
      v.q = 4'(eq); v.busy = eb; v.done = ed; v.tc = et;
      tbl.push_back(v);
   endtask

   task automatic chk(input string n, input logic [3:0] eq, input logic eb, input logic ed,
                      input logic et);
      checks++;
      if (bus.q_o !== eq || bus.busy_o !== eb || bus.done_o !== ed || bus.tc_o !== et) begin
         failures++;
         $display("FAIL %s: got q=%0d busy=%b done=%b tc=%b, expected q=%0d busy=%b done=%b tc=%b",
                  n, bus.q_o, bus.busy_o, bus.done_o, bus.tc_o, eq, eb, ed, et);
      end
   endtask

   task automatic drive(input logic ld, input logic [3:0] d, input logic st, input logic sp,
                        input logic e);
      bus.load_i = ld; bus.din_i = d; bus.start_i = st; bus.stop_i = sp; bus.en_i = e;
   endtask

   task automatic apply(input vec_t v);
      vec_t e;
      drive(v.load, v.din, v.start, v.stop, v.en);
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk(e.name, e.q, e.busy, e.done, e.tc);
   endtask

   initial begin
      int n;
      bit seen;
      drive(0, 0, 0, 0, 0);
      rst = 1'b0;
      #1 rst = 1'b1;
      #2 chk("reset_state", 0, 0, 0, 0);
      #12 rst = 1'b0;
      @(posedge clk);
      #1;

      //   name            ld din st sp en   q  b  d  tc
      add("idle_en0",       0, 0, 0, 0, 1,   0, 0, 0, 0);
      add("idle_en1",       0, 0, 0, 0, 1,   0, 0, 0, 0);
      add("load9",          1, 9, 0, 0, 0,   9, 0, 0, 0);
      add("start9",         0, 0, 1, 0, 1,   9, 1, 0, 0);
      add("dec8",           0, 0, 0, 0, 1,   8, 1, 0, 0);
      add("dec7",           0, 0, 0, 0, 1,   7, 1, 0, 0);
      add("stop7",          0, 0, 0, 1, 1,   7, 0, 0, 0);
      add("stopped_hold",   0, 0, 0, 0, 1,   7, 0, 0, 0);
      add("load0",          1, 0, 0, 0, 0,   0, 0, 0, 0);
      add("zero_start",     0, 0, 1, 0, 0,   0, 0, 1, 1);
      add("zero_done",      0, 0, 0, 0, 1,   0, 0, 1, 0);
      add("zero_restart",   0, 0, 1, 0, 0,   0, 0, 1, 1);
      add("load_over_st",   1, 2, 1, 0, 0,   2, 0, 0, 0);
      add("idle_no_run",    0, 0, 0, 0, 1,   2, 0, 0, 0);
      add("start2",         0, 0, 1, 0, 1,   2, 1, 0, 0);
      add("dec1",           0, 0, 0, 0, 1,   1, 1, 0, 0);
      add("stop_at_term",   0, 0, 0, 1, 1,   1, 0, 0, 0);
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
      add("ar_load3",       1, 3, 0, 0, 0,   3, 0, 0, 0);
      add("ar_start",       0, 0, 1, 0, 1,   3, 1, 0, 0);
      for (int p = 0; p < 3; p++) begin
         add("ar_q2",       0, 0, 0, 0, 1,   2, 1, 0, 0);
         add("ar_q1",       0, 0, 0, 0, 1,   1, 1, 0, 0);
         add("ar_reload",   0, 0, 0, 0, 1,   3, 1, 0, 1);
      end
      add("ar_stop",        0, 0, 0, 1, 1,   3, 0, 0, 0);
`else
      add("os_load5",       1, 5, 0, 0, 1,   5, 0, 0, 0);
      add("os_start",       0, 0, 1, 0, 1,   5, 1, 0, 0);
      add("os_q4",          0, 0, 0, 0, 1,   4, 1, 0, 0);
      add("os_q3",          0, 0, 0, 0, 1,   3, 1, 0, 0);
      add("os_q2",          0, 0, 0, 0, 1,   2, 1, 0, 0);
      add("os_q1",          0, 0, 0, 0, 1,   1, 1, 0, 0);
      add("os_tc",          0, 0, 0, 0, 1,   0, 0, 1, 1);
      add("os_done_hold",   0, 0, 0, 0, 1,   0, 0, 1, 0);
      add("gt_load3",       1, 3, 0, 0, 0,   3, 0, 0, 0);
      add("gt_start",       0, 0, 1, 0, 0,   3, 1, 0, 0);
      add("gt_e1",          0, 0, 0, 0, 1,   2, 1, 0, 0);
      add("gt_e0",          0, 0, 0, 0, 0,   2, 1, 0, 0);
      add("gt_e1b",         0, 0, 0, 0, 1,   1, 1, 0, 0);
      add("gt_e0b",         0, 0, 0, 0, 0,   1, 1, 0, 0);
      add("gt_tc",          0, 0, 0, 0, 1,   0, 0, 1, 1);
      add("rs_reload",      0, 0, 1, 0, 0,   3, 1, 0, 0);
      add("rs_start_ign",   0, 0, 1, 0, 1,   2, 1, 0, 0);
      add("rs_q1",          0, 0, 0, 0, 1,   1, 1, 0, 0);
      add("rs_tc",          0, 0, 0, 0, 1,   0, 0, 1, 1);
`endif
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

      // Terminal count must arrive exactly 7 en-ticks after start
      drive(1, 7, 0, 0, 0);
      @(posedge clk); #1;
      drive(0, 0, 1, 0, 1);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 1);
      n = 0;
      seen = 0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         seen = (bus.tc_o === 1'b1);
      end
      checks++;
      if (n != 7 || !seen) begin
         failures++;
         $display("FAIL tc_latency7: got %0d edges (tc seen=%0b), expected 7", n, seen);
      end
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
      chk("tc_latency7_q", 7, 1, 0, 1);
`else
      chk("tc_latency7_q", 0, 0, 1, 1);
`endif

      // Async reset in the middle of a count
      drive(1, 12, 0, 0, 0);
      @(posedge clk); #1;
      drive(0, 0, 1, 0, 1);
      @(posedge clk); #1;
      chk("mid_start12", 12, 1, 0, 0);
      drive(0, 0, 0, 0, 1);
      repeat (6) begin
         @(posedge clk); #1;
      end
      chk("mid_q6", 6, 1, 0, 0);
      #3 rst = 1'b1;
      #1 chk("mid_rst_immediate", 0, 0, 0, 0);
      @(posedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      @(posedge clk); #1;
      chk("post_rst_zero_start", 0, 0, 1, 1);
      drive(0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("post_rst_tc_single", 0, 0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
